// File: rtl/alu_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial ALU sequencer and other clients of
// the 8-bit ALU: datapath width, op-code constants and FSM state encoding.
package alu_byte_sequencer_pkg;

  localparam int unsigned ALU_W = 8;
  localparam int unsigned OP_W  = 3;

  // ALU op-codes understood by the 8-bit ALU
  localparam logic [OP_W-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_OP_AND = 3'b001;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 3'b010;
  localparam logic [OP_W-1:0] ALU_OP_XOR = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : alu_byte_sequencer_pkg

// File: rtl/alu_byte_sequencer.sv
// Multi-byte wrapper around the external 8-bit combinational ALU. Latches a
// wide operation, drives the ALU one byte per clock (LSB first) with the
// carry chained byte to byte, and assembles the wide result.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, op, opa, opb,  operation request (sampled in IDLE only)
//   cin
//   busy, done            busy in RUN/DONE; done is a one-cycle pulse
//   result, cout          assembled result and MSB carry, held until next start
//   alu_a/b/oper/cin      drive to the ALU (zero outside RUN)
//   alu_sum, alu_cout     ALU response
module alu_byte_sequencer
  import alu_byte_sequencer_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [OP_W-1:0]           op,
  input  logic [ALU_W*NBYTES-1:0]   opa,
  input  logic [ALU_W*NBYTES-1:0]   opb,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [ALU_W*NBYTES-1:0]   result,
  output logic                      cout,
  output logic [ALU_W-1:0]          alu_a,
  output logic [ALU_W-1:0]          alu_b,
  output logic [OP_W-1:0]           alu_oper,
  output logic                      alu_cin,
  input  logic [ALU_W-1:0]          alu_sum,
  input  logic                      alu_cout
);

  localparam int unsigned IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef logic [NBYTES-1:0][ALU_W-1:0] bytes_t;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  bytes_t            opa_q, opa_d;
  bytes_t            opb_q, opb_d;
  logic [OP_W-1:0]   op_q, op_d;
  bytes_t            result_q, result_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d   = opa;
          opb_d   = opb;
          op_d    = op;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[idx_q] = alu_sum;
        carry_d         = alu_cout;
        if (idx_q == IDX_LAST) begin
          // Park idx at 0 rather than letting it wrap
          idx_d   = '0;
          cout_d  = alu_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status flags registered from the next state so they line up with it
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // ALU drive, decoded only from registers; quiet outside RUN
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_oper = '0;
    alu_cin  = 1'b0;
    if (state_q == ST_RUN) begin
      alu_a    = opa_q[idx_q];
      alu_b    = opb_q[idx_q];
      alu_oper = op_q;
      alu_cin  = carry_q;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule : alu_byte_sequencer

// File: tb/tb_alu_byte_sequencer.sv
// Bench for alu_byte_sequencer (NBYTES=4) paired with a behavioural ALU stub.
module tb_alu_byte_sequencer;
  import alu_byte_sequencer_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  opa, opb;
  logic          cin;
  logic          busy, done, cout;
  logic [W-1:0]  result;
  logic [7:0]    alu_a, alu_b, alu_sum;
  logic [2:0]    alu_oper;
  logic          alu_cin, alu_cout;

  alu_byte_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout)
  );

  // Behavioural ALU: add with carry, AND / XOR pass the carry through
  function automatic logic [8:0] alu_stub(input logic [2:0] o, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
    case (o)
      ALU_OP_ADD: return 9'(a) + 9'(b) + 9'(c);
      ALU_OP_AND: return {c, a & b};
      default:    return {c, a ^ b};
    endcase
  endfunction

  always_comb {alu_cout, alu_sum} = alu_stub(alu_oper, alu_a, alu_b, alu_cin);

  // Wide reference model built from the ALU stub, byte by byte
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic c);
    logic [W-1:0] r;
    logic         cy;
    logic [8:0]   t;
    r  = '0;
    cy = c;
    for (int i = 0; i < int'(NB); i++) begin
      t = alu_stub(o, a[8*i +: 8], b[8*i +: 8], cy);
      r[8*i +: 8] = t[7:0];
      cy = t[8];
    end
    return {cy, r};
  endfunction

  typedef struct {
    logic [W-1:0] r;
    logic         c;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_r;
    logic         exp_c;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   prev_done_cyc = 0;
  int   acc_cyc = 0;
  int   base_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse pops one expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.r));
        check("cout", 64'(cout), 64'(e.c));
      end
    end
  end

  // Caller is 1 time unit after a rising edge with the DUT in IDLE
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] er, input logic ec);
    exp_t e;
    op = o; opa = a; opb = b; cin = c; start = 1'b1;
    base_cnt = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    e.r = er;
    e.c = ec;
    sb.push_back(e);
  endtask

  // Bounded wait for the done pulse of the last started op
  task automatic wait_done();
    for (int k = 0; k < 20 && done_cnt <= base_cnt; k++) @(posedge clk);
    #1;
    check("done_timeout", 64'(done_cnt > base_cnt), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    logic [W:0] m;
    logic       found;
    int         n0;

    vecs[0] = '{ALU_OP_ADD, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0};
    vecs[1] = '{ALU_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{ALU_OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{ALU_OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{ALU_OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{ALU_OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_oper", 64'(alu_oper), 64'd0);
    check("rst_alu_cin", 64'(alu_cin), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven vectors; first one also checks latency and busy
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_r, vecs[i].exp_c);
      if (i == 0) check("busy_after_accept", 64'(busy), 64'd1);
      wait_done();
      if (i == 0) begin
        check("done_latency", 64'(last_done_cyc - acc_cyc), 64'(NB));
        check("busy_after_done", 64'(busy), 64'd0);
      end
    end

    // Overflow: per-byte ALU drive, carry-in 1 on every byte
    start_op(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < int'(NB); i++) begin
      @(negedge clk);
      check("ovf_alu_cin", 64'(alu_cin), 64'd1);
      check("ovf_alu_a", 64'(alu_a), 64'hFF);
      check("ovf_alu_b", 64'(alu_b), 64'h00);
    end
    wait_done();
    @(negedge clk);
    check("idle_alu_a", 64'(alu_a), 64'd0);
    check("idle_alu_cin", 64'(alu_cin), 64'd0);
    @(posedge clk);
    #1;

    // Ignored start during RUN and during DONE
    n0 = done_cnt;
    start_op(ALU_OP_ADD, 32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF; cin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("ign_done_seen", 64'(found), 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (NB + 4) @(posedge clk);
    #1;
    check("ign_done_count", 64'(done_cnt - n0), 64'd1);
    check("ign_busy", 64'(busy), 64'd0);
    check("ign_result_held", 64'(result), 64'h1122_3344);

    // Back-to-back: second start in the cycle after done
    start_op(ALU_OP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    wait_done();
    start_op(ALU_OP_AND, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 32'h0505_0505, 1'b0);
    wait_done();
    check("b2b_spacing", 64'(last_done_cyc - prev_done_cyc), 64'(NB + 2));

    // Reset asserted at edge E2 of a RUN
    start_op(ALU_OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    void'(sb.pop_back());
    n0 = done_cnt;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_alu", 64'({alu_a, alu_b, alu_oper, alu_cin}), 64'd0);
    repeat (NB + 3) @(posedge clk);
    #1;
    check("mid_rst_no_done", 64'(done_cnt - n0), 64'd0);

    // Operand latching: inputs scrambled every RUN cycle
    m = model(ALU_OP_ADD, 32'hDEAD_BEEF, 32'h2152_4111, 1'b1);
    start_op(ALU_OP_ADD, 32'hDEAD_BEEF, 32'h2152_4111, 1'b1, m[W-1:0], m[W]);
    for (int k = 0; k < int'(NB); k++) begin
      opa = $urandom; opb = $urandom; cin = 1'($urandom); op = 3'($urandom);
      @(posedge clk);
      #1;
    end
    wait_done();

    // Random operations against the wide model
    for (int i = 0; i < 8; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      logic         rc;
      ro = (i % 3 == 0) ? ALU_OP_XOR : ((i % 3 == 1) ? ALU_OP_AND : ALU_OP_ADD);
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      m = model(ro, ra, rb, rc);
      start_op(ro, ra, rb, rc, m[W-1:0], m[W]);
      wait_done();
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_byte_sequencer
